// File: rtl/gcd_job_driver.sv
// gcd_job_driver: initiator side of the GCD core handshake.
// Takes one operand pair at a time from an upstream valid/ready source and
// pulses gcd_start for one cycle while gcd_a/gcd_b are held stable. It then
// waits for gcd_done and returns the result, tagged with a job sequence
// number, on a downstream valid/ready port. A pair with a zero operand never
// reaches the core and is answered with rsp_y=0, rsp_err=1.
// Optional feature macro: GCD_DRV_TIMEOUT_EN. When it is defined, a job that
// sees no gcd_done within TIMEOUT WAIT cycles is answered with rsp_y=0,
// rsp_err=1 and rsp_timeout=1.
module gcd_job_driver #(
  parameter int W       = 8,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [W-1:0]    req_a,
  input  logic [W-1:0]    req_b,
  output logic            gcd_start,
  output logic [W-1:0]    gcd_a,
  output logic [W-1:0]    gcd_b,
  input  logic [W-1:0]    gcd_y,
  input  logic            gcd_done,
  input  logic            gcd_error,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_y,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic [ID_W-1:0] rsp_tag,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] tag_cnt;
  logic            accept;
  logic            zero_op;
  logic            done_seen;
  logic            expire;

  // A TIMEOUT below 1 cannot express a WAIT budget; such a value is not a
  // legal configuration and this empty block only marks that range.
  if (TIMEOUT < 1) begin : g_illegal_timeout
  end

  // Handshake and event decode shared by the FSM and the datapath.
  always_comb begin
    accept    = req_valid && (state == S_IDLE);
    zero_op   = (req_a == '0) || (req_b == '0);
    // gcd_done is only meaningful while a job is actually outstanding.
    done_seen = (state == S_WAIT) && gcd_done;
  end

`ifdef GCD_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;

  // Expiry on the TIMEOUT-th WAIT cycle; a done in the same cycle wins.
  always_comb begin
    expire = (state == S_WAIT) && !gcd_done && (timer == TW'(TIMEOUT - 1));
  end

  // WAIT-cycle counter: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == S_ISSUE) begin
      timer <= '0;
    end else if (state == S_WAIT) begin
      timer <= timer + 1'b1;
    end
  end

  // Timeout flag of the held response, set only by an expired wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_timeout <= 1'b0;
    end else if (accept || done_seen) begin
      rsp_timeout <= 1'b0;
    end else if (expire) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  // Without the timer a job waits for gcd_done indefinitely.
  always_comb begin
    expire      = 1'b0;
    rsp_timeout = 1'b0;
  end
`endif

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked state is written with <= so every register samples the
      // pre-edge values; blocking writes here would race with other blocks.
      state <= state_nxt;
    end
  end

  // Next-state logic for IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is
    // inferred when a case arm leaves it untouched.
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = zero_op ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done_seen || expire) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs straight from the state, so reset forces them at once.
  always_comb begin
    req_ready = (state == S_IDLE);
    gcd_start = (state == S_ISSUE);
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
  end

  // Operand capture, result capture and job tagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_a   <= '0;
      gcd_b   <= '0;
      rsp_y   <= '0;
      rsp_err <= 1'b0;
      rsp_tag <= '0;
      tag_cnt <= '0;
    end else begin
      if (accept) begin
        gcd_a   <= req_a;
        gcd_b   <= req_b;
        rsp_tag <= tag_cnt;
        if (zero_op) begin
          rsp_y   <= '0;
          rsp_err <= 1'b1;
        end
      end
      if (done_seen) begin
        rsp_y   <= gcd_y;
        rsp_err <= gcd_error;
      end else if (expire) begin
        rsp_y   <= '0;
        rsp_err <= 1'b1;
      end
      // The tag advances only once the response has been taken; it wraps
      // naturally at 2^ID_W.
      if (rsp_valid && rsp_ready) begin
        tag_cnt <= tag_cnt + 1'b1;
      end
    end
  end

endmodule
